// File: rtl/udma_hyper_cfg_master_pkg.sv
// rtl/udma_hyper_cfg_master_pkg.sv - shared constants, FSM state type and verify masks for the cfg master
package udma_hyper_cfg_master_pkg;

  localparam int unsigned CFG_ADDR_W = 5;
  localparam int unsigned CFG_DATA_W = 32;

  localparam logic [4:0] ADDR_PAGE_BOUND       = 5'h00;
  localparam logic [4:0] ADDR_T_LATENCY_ACCESS = 5'h01;
  localparam logic [4:0] ADDR_EN_LATENCY_ADD   = 5'h02;
  localparam logic [4:0] ADDR_T_CS_MAX         = 5'h03;
  localparam logic [4:0] ADDR_T_RW_RECOVERY    = 5'h04;
  localparam logic [4:0] ADDR_RWDS_DELAY_LINE  = 5'h05;
  localparam logic [4:0] ADDR_VAR_LATENCY_CHK  = 5'h06;
  localparam logic [4:0] ADDR_N_DEVICE         = 5'h07;
  localparam logic [4:0] ADDR_MEM_SEL          = 5'h08;
  localparam logic [4:0] ADDR_TRANS_ID_ALLOC   = 5'h09;
  localparam logic [4:0] ADDR_DEST             = 5'h0A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_VERIFY = 2'd2,
    ST_RESP   = 2'd3
  } cfg_state_e;

  // Bits of each register that hold what was written; read-back compares only these.
  function automatic logic [31:0] cfg_wr_mask(input logic [4:0] addr, input int unsigned delay_bits);
    case (addr)
      ADDR_PAGE_BOUND:       cfg_wr_mask = 32'h0000_0007;
      ADDR_T_LATENCY_ACCESS: cfg_wr_mask = 32'h0000_001F;
      ADDR_EN_LATENCY_ADD:   cfg_wr_mask = 32'h0000_0001;
      ADDR_T_CS_MAX:         cfg_wr_mask = 32'hFFFF_FFFF;
      ADDR_T_RW_RECOVERY:    cfg_wr_mask = 32'hFFFF_FFFF;
      ADDR_RWDS_DELAY_LINE:  cfg_wr_mask = (32'h1 << delay_bits) - 32'h1;
      ADDR_VAR_LATENCY_CHK:  cfg_wr_mask = 32'h0000_000F;
      ADDR_N_DEVICE:         cfg_wr_mask = 32'h0000_0007;
      ADDR_MEM_SEL:          cfg_wr_mask = 32'h0000_0003;
      ADDR_DEST:             cfg_wr_mask = 32'h0000_0303;
      default:               cfg_wr_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/udma_hyper_cfg_master_if.sv
// rtl/udma_hyper_cfg_master_if.sv - request, response and cfg bus bundle with master/slave views
interface udma_hyper_cfg_master_if;
  import udma_hyper_cfg_master_pkg::*;

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [CFG_ADDR_W-1:0] req_addr_i;
  logic [CFG_DATA_W-1:0] req_wdata_i;
  logic                  req_rwn_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [CFG_DATA_W-1:0] rsp_rdata_o;
  logic                  rsp_err_o;

  logic [CFG_DATA_W-1:0] cfg_data_o;
  logic [CFG_ADDR_W-1:0] cfg_addr_o;
  logic                  cfg_valid_o;
  logic                  cfg_reg_rwn_o;
  logic [CFG_DATA_W-1:0] cfg_data_i;
  logic                  cfg_ready_i;

  modport master (
    input  req_valid_i, req_addr_i, req_wdata_i, req_rwn_i, rsp_ready_i, cfg_data_i, cfg_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output cfg_data_o, cfg_addr_o, cfg_valid_o, cfg_reg_rwn_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_wdata_i, req_rwn_i, rsp_ready_i, cfg_data_i, cfg_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  cfg_data_o, cfg_addr_o, cfg_valid_o, cfg_reg_rwn_o
  );

endinterface

// File: rtl/udma_hyper_cfg_timeout.sv
// rtl/udma_hyper_cfg_timeout.sv - wait-cycle counter that flags the last permitted cycle of a cfg transaction
module udma_hyper_cfg_timeout #(
  parameter int unsigned LIMIT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(LIMIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(LIMIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear reloads zero and wins over counting; the FSM leaves the state before the count could wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/udma_hyper_cfg_master.sv
// rtl/udma_hyper_cfg_master.sv - single-request cfg bus master with timeout; UDMA_HYPER_CFG_VERIFY_EN adds write read-back
module udma_hyper_cfg_master
  import udma_hyper_cfg_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter int unsigned DELAY_BIT_WIDTH = 3,
  parameter int unsigned ERR_CNT_WIDTH   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  udma_hyper_cfg_master_if.master  bus,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

  if (TIMEOUT_CYCLES < 2 || DELAY_BIT_WIDTH < 1 || DELAY_BIT_WIDTH > 32 || ERR_CNT_WIDTH < 1) begin : g_param_check
    $error("udma_hyper_cfg_master: illegal parameter value");
  end

  cfg_state_e              state_q, state_d;
  logic [CFG_ADDR_W-1:0]   addr_q, addr_d;
  logic [CFG_DATA_W-1:0]   wdata_q, wdata_d;
  logic                    rwn_q, rwn_d;
  logic [CFG_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                    tmo_clr, tmo_expire;
  logic                    cfg_active, cfg_rd;

`ifdef UDMA_HYPER_CFG_VERIFY_EN
  assign cfg_active = (state_q == ST_ACCESS) || (state_q == ST_VERIFY);
  assign cfg_rd     = (state_q == ST_VERIFY) ? 1'b1 : rwn_q;
`else
  assign cfg_active = (state_q == ST_ACCESS);
  assign cfg_rd     = rwn_q;
`endif

  udma_hyper_cfg_timeout #(.LIMIT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tmo_clr),
    .en_i     (cfg_active && !bus.cfg_ready_i),
    .expire_o (tmo_expire)
  );

  // Next-state and datapath: latch request, run the cfg phase(s), hold the response until taken.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rwn_d     = rwn_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    tmo_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmo_clr = 1'b1;
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          rwn_d   = bus.req_rwn_i;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bus.cfg_ready_i) begin
          rdata_d = rwn_q ? bus.cfg_data_i : '0;
          err_d   = 1'b0;
          state_d = ST_RESP;
`ifdef UDMA_HYPER_CFG_VERIFY_EN
          // TRANS_ID_ALLOC is read-only, so reading it back proves nothing.
          if (!rwn_q && (addr_q != ADDR_TRANS_ID_ALLOC)) begin
            tmo_clr = 1'b1;
            state_d = ST_VERIFY;
          end
`endif
        end else if (tmo_expire) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
`ifdef UDMA_HYPER_CFG_VERIFY_EN
      ST_VERIFY: begin
        if (bus.cfg_ready_i) begin
          rdata_d = bus.cfg_data_i;
          err_d   = |((bus.cfg_data_i ^ wdata_q) & cfg_wr_mask(addr_q, DELAY_BIT_WIDTH));
          state_d = ST_RESP;
        end else if (tmo_expire) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
`endif
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = ST_IDLE;
          if (err_q && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rwn_q     <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rwn_q     <= rwn_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Outputs decode from registers only; the cfg bus reads as all-zero while idle.
  assign bus.req_ready_o   = (state_q == ST_IDLE) && !rst_i;
  assign bus.rsp_valid_o   = (state_q == ST_RESP);
  assign bus.rsp_rdata_o   = rdata_q;
  assign bus.rsp_err_o     = err_q;
  assign bus.cfg_valid_o   = cfg_active;
  assign bus.cfg_addr_o    = cfg_active ? addr_q : '0;
  assign bus.cfg_reg_rwn_o = cfg_active && cfg_rd;
  assign bus.cfg_data_o    = (cfg_active && !cfg_rd) ? wdata_q : '0;
  assign err_cnt_o         = err_cnt_q;

endmodule

// File: tb/tb_udma_hyper_cfg_master.sv
// tb/tb_udma_hyper_cfg_master.sv - directed table-driven bench for udma_hyper_cfg_master
module tb_udma_hyper_cfg_master;
  import udma_hyper_cfg_master_pkg::*;

  localparam int unsigned TO    = 16;
  localparam int          NEVER = 1000;
  localparam int          NVEC  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] err_cnt;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         exp_cnt  = 0;

  always #5 clk = ~clk;

  udma_hyper_cfg_master_if bus();

  udma_hyper_cfg_master #(
    .TIMEOUT_CYCLES (TO),
    .DELAY_BIT_WIDTH(3),
    .ERR_CNT_WIDTH  (8)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus.master),
    .err_cnt_o(err_cnt)
  );

  typedef struct {
    logic        rwn;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    int          delay;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic rwn, input logic [4:0] addr, input logic [31:0] wdata,
                              input logic [31:0] resp, input int delay, input int hold,
                              input logic [31:0] exp_rdata, input logic exp_err, input int exp_cycles);
    vec_t v;
    v.rwn = rwn; v.addr = addr; v.wdata = wdata; v.resp = resp; v.delay = delay; v.hold = hold;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_cycles = exp_cycles;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc, cfg_cyc, wait_cnt, phase, lat;
    bit   bus_ok, seen, hold_ok;
    logic exp_rd;
    logic [31:0] hold_rdata;
    logic        hold_err;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = v.addr;
    bus.req_wdata_i = v.wdata;
    bus.req_rwn_i   = v.rwn;
    bus.cfg_ready_i = 1'b0;
    bus.cfg_data_i  = v.resp;
    check($sformatf("v%0d req_ready_idle", idx), {31'b0, bus.req_ready_o}, 32'd1);
    step();
    bus.req_valid_i = 1'b0;
    cyc = 1; cfg_cyc = 0; wait_cnt = 0; phase = 0; lat = 0; bus_ok = 1'b1; seen = 1'b0;
    while (cyc <= 40 && !seen) begin
      if (bus.rsp_valid_o) begin
        seen = 1'b1;
        lat  = cyc;
      end else begin
        if (bus.cfg_valid_o) begin
          cfg_cyc++;
          exp_rd = (phase == 0) ? v.rwn : 1'b1;
          if (bus.cfg_addr_o !== v.addr || bus.cfg_reg_rwn_o !== exp_rd ||
              bus.cfg_data_o !== (exp_rd ? 32'h0 : v.wdata) || bus.req_ready_o !== 1'b0) bus_ok = 1'b0;
          if (wait_cnt >= v.delay) begin
            bus.cfg_ready_i = 1'b1;
            phase++;
            wait_cnt = 0;
          end else begin
            bus.cfg_ready_i = 1'b0;
            wait_cnt++;
          end
        end else begin
          bus.cfg_ready_i = 1'b0;
        end
        step();
        cyc++;
      end
    end
    bus.cfg_ready_i = 1'b0;
    check($sformatf("v%0d rsp_seen", idx), {31'b0, seen}, 32'd1);
    check($sformatf("v%0d cfg_cycles", idx), cfg_cyc, v.exp_cycles);
    check($sformatf("v%0d rsp_latency", idx), lat, v.exp_cycles + 1);
    check($sformatf("v%0d cfg_bus", idx), {31'b0, bus_ok}, 32'd1);
    check($sformatf("v%0d rdata", idx), bus.rsp_rdata_o, v.exp_rdata);
    check($sformatf("v%0d err", idx), {31'b0, bus.rsp_err_o}, {31'b0, v.exp_err});
    if (v.hold > 0) begin
      hold_ok    = 1'b1;
      hold_rdata = bus.rsp_rdata_o;
      hold_err   = bus.rsp_err_o;
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 5'h07;
      bus.req_rwn_i   = 1'b1;
      for (int h = 0; h < v.hold; h++) begin
        step();
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== hold_rdata || bus.rsp_err_o !== hold_err ||
            bus.req_ready_o !== 1'b0 || bus.cfg_valid_o !== 1'b0) hold_ok = 1'b0;
      end
      bus.req_valid_i = 1'b0;
      check($sformatf("v%0d hold_stable", idx), {31'b0, hold_ok}, 32'd1);
    end
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    if (v.exp_err && exp_cnt < 255) exp_cnt++;
    check($sformatf("v%0d rsp_drop", idx), {31'b0, bus.rsp_valid_o}, 32'd0);
    check($sformatf("v%0d idle_ready", idx), {31'b0, bus.req_ready_o}, 32'd1);
    check($sformatf("v%0d idle_cfg", idx),
          {bus.cfg_valid_o, bus.cfg_reg_rwn_o, bus.cfg_addr_o, 25'b0} | bus.cfg_data_o, 32'd0);
    check($sformatf("v%0d err_cnt", idx), err_cnt, exp_cnt);
  endtask

  initial begin
    bit abort_ok, sat_ok;
    int n;

    bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.req_rwn_i = 1'b0;
    bus.rsp_ready_i = 1'b0; bus.cfg_data_i = '0; bus.cfg_ready_i = 1'b0;

    vecs[0] = mk(1'b1, ADDR_T_CS_MAX, 32'h0, 32'd665, 0, 0, 32'd665, 1'b0, 1);
`ifdef UDMA_HYPER_CFG_VERIFY_EN
    vecs[1] = mk(1'b0, ADDR_T_LATENCY_ACCESS, 32'h1F5, 32'h15, 0, 0, 32'h15, 1'b0, 2);
    vecs[7] = mk(1'b0, ADDR_T_LATENCY_ACCESS, 32'h1F5, 32'h14, 0, 0, 32'h14, 1'b1, 2);
`else
    vecs[1] = mk(1'b0, ADDR_T_LATENCY_ACCESS, 32'h1F5, 32'h15, 0, 0, 32'h0, 1'b0, 1);
    vecs[7] = mk(1'b0, ADDR_T_LATENCY_ACCESS, 32'h1F5, 32'h14, 0, 0, 32'h0, 1'b0, 1);
`endif
    vecs[2] = mk(1'b1, ADDR_DEST, 32'h0, 32'hDEADBEEF, 3, 5, 32'hDEADBEEF, 1'b0, 4);
    vecs[3] = mk(1'b1, ADDR_EN_LATENCY_ADD, 32'h0, 32'h0000AAAA, NEVER, 0, 32'h0, 1'b1, 16);
    vecs[4] = mk(1'b1, ADDR_T_RW_RECOVERY, 32'h0, 32'h12345678, 15, 2, 32'h12345678, 1'b0, 16);
    vecs[5] = mk(1'b0, ADDR_TRANS_ID_ALLOC, 32'hCAFEF00D, 32'hFFFFFFFF, 2, 0, 32'h0, 1'b0, 3);
    vecs[6] = mk(1'b0, ADDR_RWDS_DELAY_LINE, 32'h7, 32'h0, NEVER, 1, 32'h0, 1'b1, 16);

    step();
    step();
    check("reset_req_ready", {31'b0, bus.req_ready_o}, 32'd0);
    check("reset_rsp", {bus.rsp_valid_o, bus.rsp_err_o, 30'b0} | bus.rsp_rdata_o, 32'd0);
    check("reset_cfg", {bus.cfg_valid_o, bus.cfg_reg_rwn_o, bus.cfg_addr_o, 25'b0} | bus.cfg_data_o, 32'd0);
    check("reset_err_cnt", err_cnt, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Reset while a read is waiting in ACCESS.
    bus.req_valid_i = 1'b1; bus.req_addr_i = ADDR_T_CS_MAX; bus.req_rwn_i = 1'b1; bus.cfg_ready_i = 1'b0;
    step();
    bus.req_valid_i = 1'b0;
    step();
    step();
    check("abort_in_access", {31'b0, bus.cfg_valid_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_cfg_valid_drop", {31'b0, bus.cfg_valid_o}, 32'd0);
    check("abort_rsp_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
    check("abort_err_cnt", err_cnt, 32'd0);
    exp_cnt = 0;
    step();
    rst = 1'b0;
    abort_ok = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      if (bus.rsp_valid_o !== 1'b0 || bus.cfg_valid_o !== 1'b0) abort_ok = 1'b0;
    end
    check("abort_no_rsp", {31'b0, abort_ok}, 32'd1);
    check("abort_err_cnt_after", err_cnt, 32'd0);

    // Counter saturation over 300 forced timeouts.
    sat_ok = 1'b1;
    for (int k = 0; k < 300; k++) begin
      bus.req_valid_i = 1'b1; bus.req_addr_i = ADDR_MEM_SEL; bus.req_rwn_i = 1'b1;
      step();
      bus.req_valid_i = 1'b0;
      n = 0;
      while (bus.rsp_valid_o !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1 || n != TO) sat_ok = 1'b0;
      bus.rsp_ready_i = 1'b1;
      step();
      bus.rsp_ready_i = 1'b0;
      if (k == 99) check("err_cnt_100", err_cnt, 32'd100);
    end
    check("sat_all_timeouts", {31'b0, sat_ok}, 32'd1);
    check("err_cnt_saturated", err_cnt, 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/udma_hyper_cfg_master.md
# udma_hyper_cfg_master

Initiator side of the HyperBus channel configuration bus. It accepts single register-access requests from a host-side valid/ready channel and drives one cfg transaction (addr, data, valid, rwn) toward the HyperBus register file. It waits for cfg_ready_i, bounded by a timeout, and returns read data plus an error flag on a valid/ready response channel. It sits between the SoC peripheral interconnect adapter and the HyperBus channel register interface.

## Interface
- TIMEOUT_CYCLES, 16: maximum cycles cfg_valid_o stays high without cfg_ready_i; must be ≥2.
- DELAY_BIT_WIDTH, 3: width of the RWDS delay-line field; used only for verify masks.
- ERR_CNT_WIDTH, 8: width of the saturating error counter.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high. One clock domain.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_addr_i  in  5  register word address.
- req_wdata_i  in  32  write data.
- req_rwn_i  in  1  1 = read, 0 = write.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  32  read data; 0 for writes and on timeout.
- rsp_err_o  out  1  timeout, or verify mismatch when verify is compiled in.
- cfg_data_o  out  32  write data to the register file.
- cfg_addr_o  out  5  register address.
- cfg_valid_o  out  1  transaction valid.
- cfg_reg_rwn_o  out  1  1 = read.
- cfg_data_i  in  32  read data, combinational in the cycle cfg_ready_i is high.
- cfg_ready_i  in  1  transaction completes this cycle.
- err_cnt_o  out  ERR_CNT_WIDTH  count of responses sent with rsp_err_o=1; saturates at all-ones.

## Operation
- FSM states: IDLE, ACCESS, VERIFY (macro only), RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr, wdata and rwn, clear the timeout counter, and go to ACCESS.
- ACCESS:
  - cfg_valid_o=1. cfg_addr_o, cfg_data_o and cfg_reg_rwn_o come from the latched values and are held stable.
  - On cfg_ready_i:
    - For a read, capture cfg_data_i into rsp_rdata; for a write, rsp_rdata=0.
    - Set err=0, then go to RESP (or to VERIFY, see Configuration).
  - Otherwise the counter increments. If the counter equals TIMEOUT_CYCLES-1 and cfg_ready_i is low: rdata=0, err=1, go to RESP.
- RESP:
  - rsp_valid_o=1; rdata and err are held.
  - On rsp_ready_i, return to IDLE and increment err_cnt if err=1.
- req_ready_o=0 in every state except IDLE, so at most one request is outstanding.
- cfg_data_o=0 for reads. All cfg_* outputs are 0 whenever cfg_valid_o=0.
- Reset values: every output 0, state IDLE, err_cnt 0. Assertion mid-transaction aborts immediately and drops cfg_valid_o and rsp_valid_o; no response is produced.

## Timing
- Request handshake in cycle 0. cfg_valid_o is high in cycle 1.
- With cfg_ready_i high in cycle 1, rsp_valid_o is high in cycle 2. Minimum request-to-request spacing is 3 cycles.
- Timeout: cfg_valid_o is high for exactly TIMEOUT_CYCLES cycles, then rsp_valid_o rises the next cycle.
- If cfg_ready_i rises in the same cycle the counter hits TIMEOUT_CYCLES-1, ready wins: normal completion, err=0.
- No combinational path from req_* to cfg_* or from cfg_data_i to rsp_*; all are registered.

## Configuration
- Macro: UDMA_HYPER_CFG_VERIFY_EN.
- Defined: after a successful write, go to VERIFY and issue a read of the same address for one transaction, with the same timeout rules.
  - Compare (read ^ wdata) & mask(addr). Any nonzero bit or a timeout sets err=1; rsp_rdata_o returns the read-back value.
  - Writes to 0x09 (TRANS_ID_ALLOC, read-only) skip VERIFY and go straight to RESP.
  - Write response latency becomes 3 cycles.
- Undefined: the VERIFY state and mask logic are absent; writes complete in ACCESS.

## Structure
- Shared package holds:
  - The 5-bit register address constants (0x00 PAGE_BOUND through 0x0A DEST).
  - The FSM state enum.
  - A function returning the 32-bit writable mask per address:
    - 0x00 → 0x7
    - 0x01 → 0x1F
    - 0x02 → 0x1
    - 0x03, 0x04 → 0xFFFFFFFF
    - 0x05 → (1<<DELAY_BIT_WIDTH)-1
    - 0x06 → 0xF
    - 0x07 → 0x7
    - 0x08 → 0x3
    - 0x0A → 0x303
    - any other address → 0
- One sub-module: udma_hyper_cfg_timeout, a loadable counter with clear, enable and expire outputs, used by both ACCESS and VERIFY.

## Test plan
- Read of 0x03 after reset, responder ready always high → cfg_valid_o high for 1 cycle, rsp_rdata_o=665, rsp_err_o=0, rsp_valid_o two cycles after the request handshake.
- Write 0x01 data 0x1F5 with verify compiled in, responder returning 0x15 on read-back → rsp_err_o=0. With a responder returning 0x14 → rsp_err_o=1 and err_cnt_o=1.
- cfg_ready_i held low, TIMEOUT_CYCLES=16 → cfg_valid_o high for exactly 16 cycles, rsp_rdata_o=0, rsp_err_o=1.
- cfg_ready_i rising in cycle 16 of a timeout → normal completion, err=0.
- rsp_ready_i held low for 5 cycles → rsp_valid_o and rsp data stable, req_ready_o=0 throughout, and a new request is only accepted after the response handshake.
- rst_i asserted while in ACCESS → cfg_valid_o=0 in the same cycle, no response ever issued, err_cnt_o=0. 300 forced timeouts with ERR_CNT_WIDTH=8 → err_cnt_o=255.
